// File: rtl/dart_pkg.sv
// Shared types and constants for the dart league game controller.
package dart_pkg;

    // Controller states: idle awaiting a throw, scoring the latched dart, game finished
    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        SCORE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MODE_ACCUM     = 0;
    localparam int MODE_COUNTDOWN = 1;

    // Player index width covers up to 8 players
    localparam int PID_W = 3;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dart_league_game_if.sv
// Player-facing signal bundle: throw input and dart forcing in, game status out.
interface dart_league_game_if
    import dart_pkg::*;
#(
    parameter int SCORE_W = 8
);

    logic               throw_button;
    logic               dart_force_en;
    logic [4:0]         dart_force;
    logic [PID_W-1:0]   player_id;
    logic [SCORE_W-1:0] score_display;
    logic [4:0]         dart_value;
    logic               throw_valid;
    logic               bust;
    logic               game_over;
    logic [PID_W-1:0]   winner;
    logic [SCORE_W-1:0] final_score;

    modport master (
        output throw_button, dart_force_en, dart_force,
        input  player_id, score_display, dart_value, throw_valid,
               bust, game_over, winner, final_score
    );

    modport slave (
        input  throw_button, dart_force_en, dart_force,
        output player_id, score_display, dart_value, throw_valid,
               bust, game_over, winner, final_score
    );

endinterface

// File: rtl/dart_rng.sv
// Dart value source: free-running LFSR folded into 0..MAX_DART, with a forced override.
module dart_rng
    import dart_pkg::*;
#(
    parameter int MAX_DART = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dart_force_en,
    input  logic [4:0] dart_force,
    output logic [4:0] dv
);

    localparam logic [4:0] MAX_V  = 5'(MAX_DART);
    localparam logic [4:0] FOLD_V = 5'(MAX_DART + 1);

    logic [15:0] lfsr;
    logic [4:0]  raw;

    // LFSR steps every cycle so the dart depends on when the button is pressed
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // Forced value is clamped; random values above the max fold back down
    always_comb begin
        raw = lfsr[4:0];
        if (dart_force_en) begin
            dv = (dart_force > MAX_V) ? MAX_V : dart_force;
        end else if (raw > MAX_V) begin
            dv = raw - FOLD_V;
        end else begin
            dv = raw;
        end
    end

endmodule

// File: rtl/dart_league_game.sv
// Multi-player dart game controller with accumulate and x01 countdown scoring.
module dart_league_game
    import dart_pkg::*;
#(
    parameter int NUM_PLAYERS    = 4,
    parameter int NUM_ROUNDS     = 3,
    parameter int DARTS_PER_TURN = 3,
    parameter int SCORE_W        = 8,
    parameter int MAX_DART       = 20,
    parameter int MODE           = 0,
    parameter int START_SCORE    = 101
) (
    input logic              clk,
    input logic              reset,
    dart_league_game_if.slave bus
);

    localparam int NUM_SLOTS = 2 ** PID_W;
    localparam logic [SCORE_W-1:0] INIT_SCORE  =
        (MODE == MODE_COUNTDOWN) ? SCORE_W'(START_SCORE) : '0;
    localparam logic [PID_W-1:0]   LAST_PLAYER = PID_W'(NUM_PLAYERS - 1);
    localparam logic [2:0]         LAST_DART   = 3'(DARTS_PER_TURN - 1);
    localparam logic [3:0]         LAST_ROUND  = 4'(NUM_ROUNDS - 1);

    state_t             state, state_n;
    logic               btn_q;
    logic               press;
    logic [4:0]         dv;

    logic [SCORE_W-1:0] scores   [NUM_SLOTS];
    logic [SCORE_W-1:0] scores_n [NUM_SLOTS];
    logic [PID_W-1:0]   player_id, player_n;
    logic [2:0]         dart_cnt, dart_n;
    logic [3:0]         round_cnt, round_n;
    logic [4:0]         dart_value, dart_value_n;
    logic [SCORE_W-1:0] turn_start, turn_start_n;
    logic               throw_valid, throw_valid_n;
    logic               bust, bust_n;
    logic               game_over, game_over_n;
    logic [PID_W-1:0]   winner, winner_n;
    logic [SCORE_W-1:0] final_score, final_n;

    logic [SCORE_W-1:0] cur_score, turn_base, new_score;
    logic [SCORE_W:0]   dv_ext, sum;
    logic               hit_bust, hit_zero, last_dart;
    logic [PID_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best_score, cand;

    dart_rng #(.MAX_DART(MAX_DART)) u_rng (
        .clk          (clk),
        .reset        (reset),
        .dart_force_en(bus.dart_force_en),
        .dart_force   (bus.dart_force),
        .dv           (dv)
    );

    // Button is sampled even in reset so a held button never counts as a fresh press
    always_ff @(posedge clk) begin
        btn_q <= bus.throw_button;
    end

    assign press = bus.throw_button & ~btn_q;

    // Score of the current player after applying the latched dart
    always_comb begin
        cur_score = scores[player_id];
        turn_base = (dart_cnt == 3'd0) ? cur_score : turn_start;
        dv_ext    = (SCORE_W + 1)'(dart_value);
        sum       = {1'b0, cur_score} + dv_ext;
        last_dart = (dart_cnt == LAST_DART);
        hit_bust  = 1'b0;
        hit_zero  = 1'b0;
        new_score = cur_score;
        if (MODE == MODE_ACCUM) begin
            new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end else if (dv_ext > {1'b0, cur_score}) begin
            hit_bust  = 1'b1;
            new_score = turn_base;
        end else if (dv_ext == {1'b0, cur_score}) begin
            hit_zero  = 1'b1;
            new_score = '0;
        end else begin
            new_score = cur_score - SCORE_W'(dart_value);
        end
    end

    // Leader scan over the scores as they will stand after this dart; ties keep the lower index
    always_comb begin
        best_idx   = '0;
        best_score = (player_id == '0) ? new_score : scores[0];
        cand       = '0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            cand = (PID_W'(i) == player_id) ? new_score : scores[i];
            if ((MODE == MODE_ACCUM) ? (cand > best_score) : (cand < best_score)) begin
                best_idx   = PID_W'(i);
                best_score = cand;
            end
        end
    end

    // Next-state logic: latch a dart on press, score it, then advance dart/player/round
    always_comb begin
        state_n       = state;
        scores_n      = scores;
        player_n      = player_id;
        dart_n        = dart_cnt;
        round_n       = round_cnt;
        dart_value_n  = dart_value;
        turn_start_n  = turn_start;
        throw_valid_n = 1'b0;
        bust_n        = 1'b0;
        game_over_n   = game_over;
        winner_n      = winner;
        final_n       = final_score;
        case (state)
            WAIT: begin
                if (press) begin
                    dart_value_n = dv;
                    state_n      = SCORE;
                end
            end
            SCORE: begin
                throw_valid_n        = 1'b1;
                bust_n               = hit_bust;
                scores_n[player_id]  = new_score;
                state_n              = WAIT;
                if (dart_cnt == 3'd0) begin
                    turn_start_n = cur_score;
                end
                if (hit_zero) begin
                    state_n     = DONE;
                    game_over_n = 1'b1;
                    winner_n    = player_id;
                    final_n     = '0;
                end else if (hit_bust || last_dart) begin
                    dart_n = 3'd0;
                    if (player_id != LAST_PLAYER) begin
                        player_n = player_id + PID_W'(1);
                    end else if (round_cnt != LAST_ROUND) begin
                        player_n = '0;
                        round_n  = round_cnt + 4'd1;
                    end else begin
                        state_n     = DONE;
                        game_over_n = 1'b1;
                        winner_n    = best_idx;
                        final_n     = best_score;
                    end
                end else begin
                    dart_n = dart_cnt + 3'd1;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = WAIT;
            end
        endcase
    end

    // State register for the FSM, counters and score table
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= WAIT;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                scores[i] <= INIT_SCORE;
            end
            player_id   <= '0;
            dart_cnt    <= 3'd0;
            round_cnt   <= 4'd0;
            dart_value  <= 5'd0;
            turn_start  <= INIT_SCORE;
            throw_valid <= 1'b0;
            bust        <= 1'b0;
            game_over   <= 1'b0;
            winner      <= '0;
            final_score <= '0;
        end else begin
            state       <= state_n;
            scores      <= scores_n;
            player_id   <= player_n;
            dart_cnt    <= dart_n;
            round_cnt   <= round_n;
            dart_value  <= dart_value_n;
            turn_start  <= turn_start_n;
            throw_valid <= throw_valid_n;
            bust        <= bust_n;
            game_over   <= game_over_n;
            winner      <= winner_n;
            final_score <= final_n;
        end
    end

    assign bus.player_id     = player_id;
    assign bus.score_display = scores[player_id];
    assign bus.dart_value    = dart_value;
    assign bus.throw_valid   = throw_valid;
    assign bus.bust          = bust;
    assign bus.game_over     = game_over;
    assign bus.winner        = winner;
    assign bus.final_score   = final_score;

endmodule
